// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-request, fill and main-memory signals around mem_arbiter.
// The arbiter takes the master side; caches and memory take the slave side.
interface mem_arbiter_if #(
    parameter int WORDS = 8
);
    // cache requests
    logic                     i_miss;
    logic [15:0]              i_addr;
    logic                     d_miss;
    logic [15:0]              d_addr;
    logic                     d_wr;
    logic [15:0]              d_wr_addr;
    logic [15:0]              d_wr_data;
    // main memory
    logic                     mem_en;
    logic                     mem_wr;
    logic [15:0]              mem_addr;
    logic [15:0]              mem_wdata;
    logic [15:0]              mem_rdata;
    logic                     mem_valid;
    // fill path and completion
    logic [15:0]              fill_data;
    logic [$clog2(WORDS)-1:0] fill_word;
    logic                     i_fill_we;
    logic                     d_fill_we;
    logic                     i_done;
    logic                     d_done;
    logic                     d_wr_ack;
    logic                     mem_stall;

    modport master (
        input  i_miss, i_addr, d_miss, d_addr, d_wr, d_wr_addr, d_wr_data,
               mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
               i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, mem_stall
    );

    modport slave (
        output i_miss, i_addr, d_miss, d_addr, d_wr, d_wr_addr, d_wr_data,
               mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
               i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, mem_stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: serves D-cache stores, D-cache fills and
// I-cache fills one at a time, streams block reads and steers returned words.
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int WORDS   = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int              WIDX     = $clog2(WORDS);
    localparam int              IW       = WIDX + 1;
    localparam int              BW       = 16 - WIDX - 1;
    localparam logic [IW-1:0]   ISS_END  = IW'(WORDS);
    localparam logic [WIDX-1:0] RCV_LAST = WIDX'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   iss, iss_nxt;
    logic [WIDX-1:0] rcv, rcv_nxt;
    logic [BW-1:0]   base, base_nxt;

    logic            mem_en, mem_wr;
    logic [15:0]     mem_addr, mem_wdata;
    logic [WIDX-1:0] fill_word;
    logic            i_fill_we, d_fill_we, i_done, d_done, d_wr_ack;

    // Byte-offset bits and the latency parameter carry no logic here: read
    // latency is absorbed by the mem_valid handshake.
    logic unused_bits;
    assign unused_bits = ^{bus.i_addr[WIDX:0], bus.d_addr[WIDX:0], 32'(MEM_LAT)};

    // State, counters and block base; reset aborts any fill in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            iss   <= '0;
            rcv   <= '0;
            base  <= '0;
        end else begin
            state <= state_nxt;
            iss   <= iss_nxt;
            rcv   <= rcv_nxt;
            base  <= base_nxt;
        end
    end

    // Arbitration in IDLE, one-cycle store, and issue/receive sequencing of fills.
    always_comb begin
        state_nxt = state;
        iss_nxt   = iss;
        rcv_nxt   = rcv;
        base_nxt  = base;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_word = '0;
        i_fill_we = 1'b0;
        d_fill_we = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        d_wr_ack  = 1'b0;
        case (state)
            IDLE: begin
                iss_nxt = '0;
                rcv_nxt = '0;
                if (bus.d_wr) begin
                    state_nxt = WRITE;
                end else if (bus.d_miss) begin
                    state_nxt = FILL_D;
                    base_nxt  = bus.d_addr[15:WIDX+1];
                end else if (bus.i_miss) begin
                    state_nxt = FILL_I;
                    base_nxt  = bus.i_addr[15:WIDX+1];
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = bus.d_wr_addr;
                mem_wdata = bus.d_wr_data;
                d_wr_ack  = 1'b1;
                state_nxt = IDLE;
            end
            FILL_I, FILL_D: begin
                // reads go out back to back; returns are counted independently
                if (iss != ISS_END) begin
                    mem_en   = 1'b1;
                    mem_addr = {base, iss[WIDX-1:0], 1'b0};
                    iss_nxt  = iss + IW'(1);
                end
                if (bus.mem_valid) begin
                    fill_word = rcv;
                    if (state == FILL_I) i_fill_we = 1'b1;
                    else                 d_fill_we = 1'b1;
                    if (rcv == RCV_LAST) begin
                        if (state == FILL_I) i_done = 1'b1;
                        else                 d_done = 1'b1;
                        state_nxt = IDLE;
                        iss_nxt   = '0;
                        rcv_nxt   = '0;
                    end else begin
                        rcv_nxt = rcv + WIDX'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.fill_data = bus.mem_rdata;
    assign bus.fill_word = fill_word;
    assign bus.i_fill_we = i_fill_we;
    assign bus.d_fill_we = d_fill_we;
    assign bus.i_done    = i_done;
    assign bus.d_done    = d_done;
    assign bus.d_wr_ack  = d_wr_ack;
    assign bus.mem_stall = bus.i_miss | bus.d_miss | bus.d_wr | (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-LAT memory model.
module tb_mem_arbiter;
    localparam int LAT = 4;
    localparam int W   = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_arbiter_if #(.WORDS(W)) bus ();

    mem_arbiter #(.MEM_LAT(LAT), .WORDS(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // memory model state: read pipeline and a one-shot stray-valid injector
    bit          pv[LAT];
    logic [15:0] pa[LAT];
    bit          stray = 1'b0;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the memory sees this cycle's command at the edge.
    task automatic tick();
        bit          rd_now;
        logic [15:0] a_now;
        rd_now = (bus.mem_en === 1'b1) && (bus.mem_wr === 1'b0);
        a_now  = bus.mem_addr;
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = rd_now;
        pa[0] = a_now;
        if (rst) for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
        bus.mem_valid = pv[LAT-1];
        bus.mem_rdata = pv[LAT-1] ? mem_f(pa[LAT-1]) : 16'h0000;
        if (stray) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = 16'hDEAD;
            stray = 1'b0;
        end
    endtask

    task automatic chk_idle(input string tag, input bit stall);
        chk({tag, " en"},    bus.mem_en, 0);
        chk({tag, " addr"},  bus.mem_addr, 0);
        chk({tag, " wdata"}, bus.mem_wdata, 0);
        chk({tag, " ifwe"},  bus.i_fill_we, 0);
        chk({tag, " dfwe"},  bus.d_fill_we, 0);
        chk({tag, " idone"}, bus.i_done, 0);
        chk({tag, " ddone"}, bus.d_done, 0);
        chk({tag, " ack"},   bus.d_wr_ack, 0);
        chk({tag, " word"},  16'(bus.fill_word), 0);
        chk({tag, " stall"}, bus.mem_stall, 16'(stall));
    endtask

    task automatic chk_write(input string tag, input logic [15:0] a, input logic [15:0] d);
        chk({tag, " en"},    bus.mem_en, 1);
        chk({tag, " wr"},    bus.mem_wr, 1);
        chk({tag, " addr"},  bus.mem_addr, a);
        chk({tag, " wdata"}, bus.mem_wdata, d);
        chk({tag, " ack"},   bus.d_wr_ack, 1);
        chk({tag, " dfwe"},  bus.d_fill_we, 0);
    endtask

    // Fill cycles k_lo..k_hi relative to the grant cycle; raises a store at k==wr_at.
    task automatic run_fill(input string tag, input bit is_d, input logic [15:0] base,
                            input int k_lo, input int k_hi, input int wr_at);
        for (int k = k_lo; k <= k_hi; k++) begin
            bit          en, we, dn;
            logic [15:0] ea;
            string       t;
            tick();
            if (k == wr_at) begin
                bus.d_wr      = 1'b1;
                bus.d_wr_addr = 16'h3456;
                bus.d_wr_data = 16'h1357;
            end
            @(negedge clk);
            t  = $sformatf("%s k%0d", tag, k);
            en = (k <= W);
            we = (k > LAT) && (k <= W + LAT);
            dn = (k == W + LAT);
            ea = en ? base + 16'((k - 1) * 2) : 16'h0000;
            chk({t, " en"},    bus.mem_en, 16'(en));
            chk({t, " wr"},    bus.mem_wr, 0);
            chk({t, " addr"},  bus.mem_addr, ea);
            chk({t, " ifwe"},  bus.i_fill_we, 16'(we && !is_d));
            chk({t, " dfwe"},  bus.d_fill_we, 16'(we && is_d));
            chk({t, " idone"}, bus.i_done, 16'(dn && !is_d));
            chk({t, " ddone"}, bus.d_done, 16'(dn && is_d));
            chk({t, " ack"},   bus.d_wr_ack, 0);
            chk({t, " stall"}, bus.mem_stall, 1);
            if (we) begin
                chk({t, " word"}, 16'(bus.fill_word), 16'(k - LAT - 1));
                chk({t, " data"}, bus.fill_data, mem_f(base + 16'((k - LAT - 1) * 2)));
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_miss    = 1'b0;
        bus.i_addr    = '0;
        bus.d_miss    = 1'b0;
        bus.d_addr    = '0;
        bus.d_wr      = 1'b0;
        bus.d_wr_addr = '0;
        bus.d_wr_data = '0;
        bus.mem_rdata = '0;
        bus.mem_valid = 1'b0;

        // reset state
        tick();
        tick();
        @(negedge clk);
        chk_idle("rst", 0);
        chk("rst wr", bus.mem_wr, 0);
        chk("rst fdata", bus.fill_data, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post rst", 0);

        // lone I-cache fill of 0x1234
        tick();
        bus.i_miss = 1'b1;
        bus.i_addr = 16'h1234;
        @(negedge clk);
        chk_idle("t1 c0", 1);
        run_fill("t1", 0, 16'h1230, 1, 12, 0);
        tick();
        bus.i_miss = 1'b0;
        @(negedge clk);
        chk_idle("t1 c13", 0);

        // simultaneous misses: D first, I granted after the single IDLE cycle 13,
        // so the I fill issues in cycle 14 and completes 12 cycles after its grant
        tick();
        bus.d_miss = 1'b1;
        bus.d_addr = 16'h4000;
        bus.i_miss = 1'b1;
        bus.i_addr = 16'h0010;
        @(negedge clk);
        chk_idle("t2 c0", 1);
        run_fill("t2d", 1, 16'h4000, 1, 12, 0);
        tick();
        bus.d_miss = 1'b0;
        @(negedge clk);
        chk_idle("t2 c13", 1);
        run_fill("t2i", 0, 16'h0010, 1, 12, 0);
        tick();
        bus.i_miss = 1'b0;
        @(negedge clk);
        chk_idle("t2 end", 0);

        // store beats a same-cycle D miss
        tick();
        bus.d_wr      = 1'b1;
        bus.d_wr_addr = 16'h2002;
        bus.d_wr_data = 16'hBEEF;
        bus.d_miss    = 1'b1;
        bus.d_addr    = 16'h6A5E;
        @(negedge clk);
        chk_idle("t3 c0", 1);
        tick();
        @(negedge clk);
        chk_write("t3 c1", 16'h2002, 16'hBEEF);
        tick();
        bus.d_wr = 1'b0;
        @(negedge clk);
        chk_idle("t3 c2", 1);
        run_fill("t3d", 1, 16'h6A50, 1, 12, 0);
        tick();
        bus.d_miss = 1'b0;
        @(negedge clk);
        chk_idle("t3 end", 0);

        // store raised mid I fill waits for the fill to finish
        tick();
        bus.i_miss = 1'b1;
        bus.i_addr = 16'h0BC8;
        @(negedge clk);
        chk_idle("t4 c0", 1);
        run_fill("t4i", 0, 16'h0BC0, 1, 12, 3);
        tick();
        bus.i_miss = 1'b0;
        @(negedge clk);
        chk_idle("t4 c13", 1);
        tick();
        @(negedge clk);
        chk_write("t4 c14", 16'h3456, 16'h1357);
        tick();
        bus.d_wr = 1'b0;
        @(negedge clk);
        chk_idle("t4 end", 0);

        // reset in cycle 6 of a D fill with the miss still held
        tick();
        bus.d_miss = 1'b1;
        bus.d_addr = 16'h7FF0;
        @(negedge clk);
        chk_idle("t5 c0", 1);
        run_fill("t5a", 1, 16'h7FF0, 1, 5, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_idle("t5 c7", 1);
        chk("t5 c7 wr", bus.mem_wr, 0);
        run_fill("t5b", 1, 16'h7FF0, 1, 12, 0);
        tick();
        bus.d_miss = 1'b0;
        @(negedge clk);
        chk_idle("t5 end", 0);

        // stray mem_valid while IDLE, then a fill must still start at word 0
        stray = 1'b1;
        tick();
        @(negedge clk);
        chk_idle("t6 stray", 0);
        tick();
        bus.i_miss = 1'b1;
        bus.i_addr = 16'h5550;
        @(negedge clk);
        chk_idle("t6 c0", 1);
        run_fill("t6i", 0, 16'h5550, 1, 12, 0);
        tick();
        bus.i_miss = 1'b0;
        @(negedge clk);
        chk_idle("t6 end", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
